// File: rtl/ram_refresh_pkg.sv
// ram_refresh_pkg
// Shared constants and helpers for the DRAM refresh scheduler.
//   REF_*_DEF : default parameter values used by ram_refresh_sched.
//   ref_dw()  : width needed to hold a count of 0..n.
package ram_refresh_pkg;

  localparam int REF_INTERVAL_DEF = 250;
  localparam int REF_URG_AGE_DEF  = 64;
  localparam int REF_MAX_DEBT_DEF = 4;
  localparam int REF_URG_DEBT_DEF = 2;

  // Bits needed to represent every value 0..n (n >= 1).
  function automatic int ref_dw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ram_refresh_sched_timer.sv
// refresh_interval_timer
// Free-running modulo-INTERVAL counter. Counts only while En is high and
// emits a one-cycle Tick at the edge where the count wraps.
//   CLK  in  : system clock
//   RST  in  : asynchronous active-high reset
//   En   in  : count enable; low freezes the count
//   Tick out : high while count == INTERVAL-1 and En == 1
module refresh_interval_timer #(
  parameter int INTERVAL = 250
) (
  input  logic CLK,
  input  logic RST,
  input  logic En,
  output logic Tick
);

  localparam int TW = $clog2(INTERVAL);
  localparam logic [TW-1:0] LAST = TW'(INTERVAL - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    Tick    = En && (count_q == LAST);
    count_d = count_q;
    if (Tick)    count_d = '0;
    else if (En) count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/ram_refresh_sched.sv
// ram_refresh_sched
// DRAM refresh scheduler. Accumulates owed refreshes (debt) from a fixed
// interval timer, requests refresh while debt is owed, escalates to urgent
// on request age or debt level, and retires one refresh per accepted ack.
//   CLK     in  : system clock
//   RST     in  : asynchronous active-high reset
//   RefEn   in  : refresh enable; low freezes timer/debt/age, outputs low
//   RefAck  in  : one-cycle pulse, controller started a refresh
//   RefReq  out : registered refresh request
//   RefUrg  out : registered urgent refresh request
//   RefDebt out : owed-refresh count
//   RefOvf  out : sticky, tick arrived with debt already at its cap
// Optional feature macro: REFRESH_DEBT_EN (debt cap MAX_DEBT and urgency on
// debt >= URG_DEBT). Without it the cap is 1 and urgency is by age only.
module ram_refresh_sched
  import ram_refresh_pkg::*;
#(
  parameter int INTERVAL = REF_INTERVAL_DEF,
  parameter int URG_AGE  = REF_URG_AGE_DEF,
  parameter int MAX_DEBT = REF_MAX_DEBT_DEF,
  parameter int URG_DEBT = REF_URG_DEBT_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        RefEn,
  input  logic                        RefAck,
  output logic                        RefReq,
  output logic                        RefUrg,
  output logic [ref_dw(MAX_DEBT)-1:0] RefDebt,
  output logic                        RefOvf
);

  localparam int DW = ref_dw(MAX_DEBT);
  localparam int AW = ref_dw(URG_AGE);

`ifdef REFRESH_DEBT_EN
  localparam bit DEBT_EN = 1'b1;
`else
  localparam bit DEBT_EN = 1'b0;
`endif

  // With the cap at 1 the upper debt bits can never be set.
  localparam logic [DW-1:0] CAP     = DEBT_EN ? DW'(MAX_DEBT) : DW'(1);
  localparam logic [DW-1:0] URG_LVL = DW'(URG_DEBT);
  localparam logic [AW-1:0] AGE_MAX = AW'(URG_AGE);

  logic          tick;
  logic          ack_acc;
  logic          holdoff_d;
  logic [DW-1:0] debt_q, debt_d;
  logic [AW-1:0] age_q, age_d;
  logic          req_q, req_d;
  logic          urg_q, urg_d;
  logic          ovf_q, ovf_d;

  refresh_interval_timer #(
    .INTERVAL(INTERVAL)
  ) u_timer (
    .CLK (CLK),
    .RST (RST),
    .En  (RefEn),
    .Tick(tick)
  );

  always_comb begin
    // An ack landing on a tick consumes that tick's refresh, so it counts
    // as accepted even when no debt was owed before the edge.
    ack_acc = RefAck && ((debt_q != '0) || tick);

    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !RefAck) begin
      if (debt_q == CAP) ovf_d  = 1'b1;
      else               debt_d = debt_q + 1'b1;
    end else if (!tick && ack_acc) begin
      debt_d = debt_q - 1'b1;
    end

    // Age measures time since the current request became owed; it only
    // advances on debt already present so urgency lands URG_AGE cycles
    // after RefReq rises.
    age_d = age_q;
    if ((debt_d == '0) || ack_acc)
      age_d = '0;
    else if (RefEn && (debt_q != '0) && (age_q < AGE_MAX))
      age_d = age_q + 1'b1;

    // One forced-low cycle after each accepted ack lets the controller
    // re-arm its refresh-done latch between back-to-back refreshes.
    holdoff_d = ack_acc;

    req_d = RefEn && !holdoff_d && (debt_d != '0);
    urg_d = req_d && ((age_d >= AGE_MAX) || (DEBT_EN && (debt_d >= URG_LVL)));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      debt_q <= '0;
      age_q  <= '0;
      req_q  <= 1'b0;
      urg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      debt_q <= debt_d;
      age_q  <= age_d;
      req_q  <= req_d;
      urg_q  <= urg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign RefReq  = req_q;
  assign RefUrg  = urg_q;
  assign RefDebt = debt_q;
  assign RefOvf  = ovf_q;

endmodule
